// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a byte FIFO.
// TXDATA at BASE_ADDR (store pushes a byte), STATUS at BASE_ADDR+4.
// STATUS = {count[3:0], ovf, busy, empty, full}; a store with wdata[3]=1 clears ovf.
// Optional macro MMIO_UART_TX_PARITY_EN adds an even-parity bit (11-bit frame)
// and makes STATUS bit 8 read 1.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_FF00,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        sel,
  output logic        tx,
  output logic        irq_empty
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
`ifdef MMIO_UART_TX_PARITY_EN
  localparam logic PAR_FLAG = 1'b1;
`else
  localparam logic PAR_FLAG = 1'b0;
`endif

`ifdef MMIO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [7:0]      fifo_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic            tx_q, tx_d;
  logic            irq_q, irq_d;
`ifdef MMIO_UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic            hit_data, hit_stat;
  logic            full, empty, busy;
  logic            push_req, push, pop, clr;
  logic [4:0]      count_w;
  logic [31:0]     status_w;
  logic            unused_bits;

  assign hit_data = (mem_addr[31:2] == BASE_ADDR[31:2]);
  assign hit_stat = (mem_addr[31:2] == (BASE_ADDR[31:2] + 30'd1));
  assign sel      = hit_data | hit_stat;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign busy     = (state_q != ST_IDLE);
  assign count_w  = 5'(count_q);
  assign status_w = {23'b0, PAR_FLAG, count_w[3:0], ovf_q, busy, empty, full};

  assign mem_rdata = (mem_re && hit_stat) ? status_w : '0;
  assign tx        = tx_q;
  assign irq_empty = irq_q;

  assign unused_bits = ^{mem_wdata[31:8], mem_addr[1:0]};

  // Next-state logic: FIFO push/pop, overflow flag, and the frame sequencer.
  always_comb begin
    state_d  = state_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    baud_d   = baud_q;
    tx_d     = 1'b1;
    irq_d    = 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    pop      = 1'b0;
    push_req = mem_we && hit_data;
    push     = push_req && !full;
    clr      = mem_we && hit_stat && mem_wdata[3];

    // A fresh overflow takes priority over a clear in the same cycle.
    if (push_req && full) begin
      ovf_d = 1'b1;
    end else if (clr) begin
      ovf_d = 1'b0;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = mem_wdata[7:0];
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = fifo_q[rd_ptr_q];
`ifdef MMIO_UART_TX_PARITY_EN
          parity_d = ^fifo_q[rd_ptr_q];
`endif
          rd_ptr_d = rd_ptr_q + PW'(1);
          bit_d    = '0;
          baud_d   = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // tx and irq are registered, so they are derived from the next state.
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef MMIO_UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
    irq_d = (count_d == '0) && (state_d == ST_IDLE);
  end

  // State registers with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      shift_q  <= '0;
      bit_q    <= '0;
      baud_q   <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
